// File: rtl/lab3_func_monitor.sv
// Purpose : registered, glitch-filtered B[W-1] & reduce(B[W-2:0]) with rise pulse and saturating event counter.
// Latency : B sampled into b_q on edge t0; F/rise update on edge t0+STABLE when raw holds steady.
// Backpr. : none; free-running monitor, every output is a flop and no input reaches an output combinationally.
module lab3_func_monitor #(
    parameter int W      = 3,
    parameter int STABLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     B,
    input  logic             mode,
    input  logic             clr,
    output logic             F,
    output logic             rise,
    output logic [CNT_W-1:0] count
);

    // Stability counter only needs to reach STABLE-1; the extra bit keeps STABLE=1 legal.
    localparam int              SW      = $clog2(STABLE) + 1;
    localparam logic [SW-1:0]   LAST    = SW'(STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [W-1:0]     b_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic             f_q, f_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             red;
    logic             raw;

    // Unfiltered function of the registered switches; mode is used live so a mode
    // flip is indistinguishable from an input change and goes through the filter.
    always_comb begin
        red = mode ? (&b_q[W-2:0]) : (|b_q[W-2:0]);
        raw = b_q[W-1] & red;
    end

    // Next-state: glitch filter, 0->1 edge detect, saturating counter with clear priority.
    always_comb begin
        stab_d  = stab_q;
        f_d     = f_q;
        rise_d  = 1'b0;
        count_d = count_q;

        if (raw == f_q) begin
            // Any agreeing cycle discards partial progress toward a change.
            stab_d = '0;
        end else if (stab_q == LAST) begin
            f_d    = raw;
            stab_d = '0;
        end else begin
            stab_d = stab_q + SW'(1);
        end

        rise_d = f_d & ~f_q;

        if (clr) begin
            count_d = '0;
        end else if (rise_d && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers; synchronous reset wins over every other input on its edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q     <= '0;
            stab_q  <= '0;
            f_q     <= 1'b0;
            rise_q  <= 1'b0;
            count_q <= '0;
        end else begin
            b_q     <= B;
            stab_q  <= stab_d;
            f_q     <= f_d;
            rise_q  <= rise_d;
            count_q <= count_d;
        end
    end

    assign F     = f_q;
    assign rise  = rise_q;
    assign count = count_q;

endmodule

// File: tb/tb_lab3_func_monitor.sv
// Purpose : directed scoreboard bench for lab3_func_monitor in three parameter sets.
// Latency : expectations are queued before each edge and checked 1 ns after it.
// Backpr. : none; every wait is a fixed number of clock edges.
module tb_lab3_func_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] b;
    logic       mode;
    logic       clr;

    logic       fa, ra;
    logic [7:0] ca;
    logic       fb, rb;
    logic [1:0] cb;
    logic       fc, rc;
    logic [7:0] cc;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        int         id;
        logic [9:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lab3_func_monitor #(.W(3), .STABLE(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .B(b), .mode(mode), .clr(clr),
        .F(fa), .rise(ra), .count(ca)
    );

    lab3_func_monitor #(.W(3), .STABLE(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .B(b), .mode(mode), .clr(clr),
        .F(fb), .rise(rb), .count(cb)
    );

    lab3_func_monitor #(.W(2), .STABLE(1), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .B(b[1:0]), .mode(mode), .clr(clr),
        .F(fc), .rise(rc), .count(cc)
    );

    function automatic logic [9:0] obs(input int id);
        case (id)
            0:       obs = {fa, ra, ca};
            1:       obs = {fb, rb, 6'd0, cb};
            default: obs = {fc, rc, cc};
        endcase
    endfunction

    task automatic push(input string tag, input int id, input logic f, input logic r, input int c);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.exp = {f, r, 8'(c)};
        sb.push_back(e);
    endtask

    // Advance one edge, then drain the scoreboard against the sampled outputs.
    task automatic tick();
        exp_t       e;
        logic [9:0] got;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = obs(e.id);
            n_cmp++;
            assert (got === e.exp) else begin
                n_err++;
                $error("FAIL %s dut%0d: got F=%b rise=%b count=%0d, want F=%b rise=%b count=%0d",
                       e.tag, e.id, got[9], got[8], got[7:0], e.exp[9], e.exp[8], e.exp[7:0]);
            end
        end
    endtask

    initial begin
        logic [1:0] seq [0:8];
        logic       f_exp, prev_f, r_exp;
        int         c_exp;

        // Reset, with inputs that would otherwise make raw=1.
        reset = 1'b1; b = 3'b111; mode = 1'b0; clr = 1'b0;
        tick();
        push("reset", 0, 0, 0, 0); push("reset", 1, 0, 0, 0); push("reset", 2, 0, 0, 0);
        tick();

        // 1: default filter latency, rise pulse, first count.
        reset = 1'b0; b = 3'b101;
        for (int k = 1; k <= 6; k++) begin
            push("t1_lat", 0, k >= 5, k == 5, (k >= 5) ? 1 : 0);
            push("t1_lat", 1, k >= 5, k == 5, (k >= 5) ? 1 : 0);
            tick();
        end

        // 2: fall produces no pulse; a 3-cycle glitch is rejected.
        b = 3'b000;
        for (int k = 1; k <= 5; k++) begin push("t2_fall", 0, k < 5, 0, 1); tick(); end
        b = 3'b110;
        for (int k = 1; k <= 3; k++) begin push("t2_glitch", 0, 0, 0, 1); tick(); end
        b = 3'b000;
        for (int k = 1; k <= 4; k++) begin push("t2_after", 0, 0, 0, 1); tick(); end

        // 3: mode sweep.
        b = 3'b101; mode = 1'b1;
        for (int k = 1; k <= 6; k++) begin push("t3_and101", 0, 0, 0, 1); tick(); end
        mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push("t3_or101", 0, k >= 4, k == 4, (k >= 4) ? 2 : 1); tick();
        end
        b = 3'b111; mode = 1'b1;
        for (int k = 1; k <= 6; k++) begin push("t3_hold", 0, 1, 0, 2); tick(); end
        b = 3'b000;
        for (int k = 1; k <= 5; k++) begin push("t3_fall", 0, k < 5, 0, 2); tick(); end
        b = 3'b111;
        for (int k = 1; k <= 6; k++) begin
            push("t3_and111", 0, k >= 5, k == 5, (k >= 5) ? 3 : 2); tick();
        end

        // 4: clear, saturation of the 2-bit counter, clear beating a rise.
        b = 3'b100; mode = 1'b0; clr = 1'b1;
        push("t4_clr", 0, 1, 0, 0); push("t4_clr", 1, 1, 0, 0);
        tick();
        clr = 1'b0;
        for (int k = 2; k <= 5; k++) begin push("t4_fall", 0, k < 5, 0, 0); tick(); end
        for (int i = 1; i <= 5; i++) begin
            b = 3'b110;
            for (int k = 1; k <= 5; k++) begin
                push("t4_rise", 0, k == 5, k == 5, (k == 5) ? i : i - 1);
                push("t4_sat", 1, k == 5, k == 5, (k == 5) ? ((i > 3) ? 3 : i) : ((i - 1 > 3) ? 3 : i - 1));
                tick();
            end
            b = 3'b100;
            for (int k = 1; k <= 5; k++) begin push("t4_low", 0, k < 5, 0, i); tick(); end
        end
        b = 3'b110;
        for (int k = 1; k <= 4; k++) begin push("t4_pre", 0, 0, 0, 5); tick(); end
        clr = 1'b1;
        push("t4_clr_rise", 0, 1, 1, 0); push("t4_clr_rise", 1, 1, 1, 0);
        tick();
        clr = 1'b0;
        push("t4_post", 0, 1, 0, 0);
        tick();

        // 5: reset in the middle of a pending change.
        b = 3'b011;
        for (int k = 1; k <= 5; k++) begin push("t5_low", 0, k < 5, 0, 0); tick(); end
        b = 3'b111;
        for (int k = 1; k <= 3; k++) begin push("t5_pend", 0, 0, 0, 0); tick(); end
        reset = 1'b1;
        push("t5_rst", 0, 0, 0, 0); push("t5_rst", 1, 0, 0, 0); push("t5_rst", 2, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push("t5_refill", 0, k == 5, k == 5, (k == 5) ? 1 : 0);
            push("t5_refill", 1, k == 5, k == 5, (k == 5) ? 1 : 0);
            tick();
        end

        // 6: W=2, STABLE=1 follows b_q one edge later, pulsing on each rise.
        reset = 1'b1;
        push("t6_rst", 2, 0, 0, 0);
        tick();
        reset = 1'b0;
        seq[0] = 2'b11; seq[1] = 2'b00; seq[2] = 2'b11; seq[3] = 2'b10; seq[4] = 2'b11;
        seq[5] = 2'b01; seq[6] = 2'b11; seq[7] = 2'b11; seq[8] = 2'b11;
        prev_f = 1'b0;
        c_exp  = 0;
        for (int j = 0; j <= 8; j++) begin
            b     = {1'b0, seq[j]};
            f_exp = (j == 0) ? 1'b0 : (seq[j-1] == 2'b11);
            r_exp = f_exp & ~prev_f;
            if (r_exp) c_exp++;
            push("t6_follow", 2, f_exp, r_exp, c_exp);
            tick();
            prev_f = f_exp;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
